// File: rtl/regfile_pkg.sv
// Shared register-file constants and the select-width helper used by the
// read mux and its selection tree.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;

  // Number of index bits needed to address depth words.
  function automatic int sel_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage : regfile_pkg

// File: rtl/muxn_1.sv
// N:1 word selector built as a recursive binary tree of 2:1 stages.
// Each level splits the word array in half and lets the index MSB pick
// between the two sub-trees; a two-word array is the leaf.
module muxn_1
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int SEL_W = sel_w(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       out_data
);

  if (DEPTH == 2) begin : g_leaf
    // Leaf 2:1 stage.
    assign out_data = sel[0] ? in_data[2*WIDTH-1:WIDTH] : in_data[WIDTH-1:0];
  end else begin : g_split
    localparam int HALF = DEPTH / 2;

    logic [WIDTH-1:0] lo_data;
    logic [WIDTH-1:0] hi_data;

    muxn_1 #(.WIDTH(WIDTH), .DEPTH(HALF)) u_lo (
      .in_data (in_data[HALF*WIDTH-1:0]),
      .sel     (sel[SEL_W-2:0]),
      .out_data(lo_data)
    );

    muxn_1 #(.WIDTH(WIDTH), .DEPTH(HALF)) u_hi (
      .in_data (in_data[DEPTH*WIDTH-1:HALF*WIDTH]),
      .sel     (sel[SEL_W-2:0]),
      .out_data(hi_data)
    );

    // Top-level 2:1 stage picks the half addressed by the index MSB.
    assign out_data = sel[SEL_W-1] ? hi_data : lo_data;
  end

endmodule : muxn_1

// File: rtl/regread_mux.sv
// Register read port: selects one word of a flattened register array,
// applies same-cycle write forwarding and the optional zero register, and
// presents the result one cycle later behind a valid/ready handshake.
module regread_mux
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  bit ZERO_REG = 1'b1,
  localparam int SEL_W    = sel_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH*WIDTH-1:0] in_data,
  input  logic                   req_valid,
  input  logic [SEL_W-1:0]       req_sel,
  output logic                   req_ready,
  input  logic                   fwd_en,
  input  logic [SEL_W-1:0]       fwd_sel,
  input  logic [WIDTH-1:0]       fwd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DEPTH - 1);

  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] next_data;
  logic             accept;
  logic             is_zero;
  logic             fwd_hit;

  muxn_1 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
    .in_data (in_data),
    .sel     (req_sel),
    .out_data(mux_data)
  );

  // The output slot can take a new request when empty or being drained.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign is_zero   = ZERO_REG && (req_sel == LAST_SEL);
  assign fwd_hit   = fwd_en && (fwd_sel == req_sel);

  // Priority: zero register, then in-flight write, then stored word.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    next_data = mux_data;
    if (is_zero) begin
      next_data = '0;
    end else if (fwd_hit) begin
      next_data = fwd_data;
    end
  end

  // Response register: load on accept, empty on drain, hold on stall.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= next_data;
    end else if (rsp_ready) begin
      // No accept while ready is high implies no request: the slot drains.
      // rsp_data keeps its last value; consumers ignore it while invalid.
      rsp_valid <= 1'b0;
    end
  end

endmodule : regread_mux

// File: tb/tb_regread_mux.sv
// Directed bench for regread_mux: one instance with the zero register and
// one without, sharing all inputs so the zero-register contrast is direct.
module tb_regread_mux;

  localparam int W = 64;
  localparam int D = 32;

  logic           clk;
  logic           reset;
  logic [D*W-1:0] in_data;
  logic           req_valid;
  logic [4:0]     req_sel;
  logic           fwd_en;
  logic [4:0]     fwd_sel;
  logic [W-1:0]   fwd_data;
  logic           rsp_ready;

  logic           rdy_z, vld_z;
  logic [W-1:0]   dat_z;
  logic           rdy_n, vld_n;
  logic [W-1:0]   dat_n;

  int n_checks = 0;
  int n_fail   = 0;

  regread_mux #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) u_zr (
    .clk(clk), .reset(reset), .in_data(in_data),
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(rdy_z),
    .fwd_en(fwd_en), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .rsp_valid(vld_z), .rsp_ready(rsp_ready), .rsp_data(dat_z)
  );

  regread_mux #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) u_nz (
    .clk(clk), .reset(reset), .in_data(in_data),
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(rdy_n),
    .fwd_en(fwd_en), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .rsp_valid(vld_n), .rsp_ready(rsp_ready), .rsp_data(dat_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   sel;
    logic         fen;
    logic [4:0]   fsel;
    logic [W-1:0] fdata;
    logic [W-1:0] exp_z;
    logic [W-1:0] exp_n;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    req_valid = 1'b0;
    req_sel   = '0;
    fwd_en    = 1'b0;
    fwd_sel   = '0;
    fwd_data  = '0;
    rsp_ready = 1'b1;

    for (int i = 0; i < D; i++) set_word(i, W'(i + 1));
    set_word(5, 64'h1234);
    set_word(7, 64'hAAAA);
    set_word(31, 64'hFFFF);

    // Reset state.
    step();
    check("reset_valid", {63'd0, vld_z}, 64'd0);
    check("reset_data", dat_z, 64'd0);
    check("reset_ready", {63'd0, rdy_z}, 64'd1);
    reset = 1'b0;

    // Single-request vectors, each read back one cycle later.
    vecs[0] = '{5'd5,  1'b0, 5'd0,  64'h0,        64'h1234, 64'h1234};
    vecs[1] = '{5'd7,  1'b1, 5'd7,  64'h5555,     64'h5555, 64'h5555};
    vecs[2] = '{5'd7,  1'b1, 5'd6,  64'h5555,     64'hAAAA, 64'hAAAA};
    vecs[3] = '{5'd31, 1'b1, 5'd31, 64'h1234ABCD, 64'h0,    64'h1234ABCD};
    vecs[4] = '{5'd31, 1'b0, 5'd0,  64'h0,        64'h0,    64'hFFFF};
    vecs[5] = '{5'd0,  1'b0, 5'd0,  64'h0,        64'h1,    64'h1};
    vecs[6] = '{5'd3,  1'b0, 5'd3,  64'h99,       64'h4,    64'h4};

    for (int k = 0; k < 7; k++) begin
      req_valid = 1'b1;
      req_sel   = vecs[k].sel;
      fwd_en    = vecs[k].fen;
      fwd_sel   = vecs[k].fsel;
      fwd_data  = vecs[k].fdata;
      rsp_ready = 1'b1;
      step();
      check($sformatf("vec%0d_valid", k), {63'd0, vld_z}, 64'd1);
      check($sformatf("vec%0d_zr_data", k), dat_z, vecs[k].exp_z);
      check($sformatf("vec%0d_nz_data", k), dat_n, vecs[k].exp_n);
    end

    // Exhaustive select, back-to-back with no bubbles.
    for (int i = 0; i < D; i++) set_word(i, W'(i + 1));
    fwd_en = 1'b0;
    for (int i = 0; i < D; i++) begin
      req_sel = 5'(i);
      step();
      check($sformatf("sweep%0d_nz", i), dat_n, W'(i + 1));
      check($sformatf("sweep%0d_zr", i), dat_z, (i == D - 1) ? 64'd0 : W'(i + 1));
    end

    // Back-pressure: response 0x11 held through a 3-cycle stall.
    req_sel = 5'd16;
    step();
    check("bp_load", dat_z, 64'h11);
    rsp_ready = 1'b0;
    req_sel   = 5'd20;
    fwd_en    = 1'b1;
    fwd_sel   = 5'd20;
    fwd_data  = 64'hDEAD;
    #1;
    check("bp_ready_low", {63'd0, rdy_z}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp_hold%0d_data", c), dat_z, 64'h11);
      check($sformatf("bp_hold%0d_valid", c), {63'd0, vld_z}, 64'd1);
      check($sformatf("bp_hold%0d_ready", c), {63'd0, rdy_z}, 64'd0);
    end
    // Release: the earlier forwarding must not have been captured.
    fwd_en    = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_release", {63'd0, rdy_z}, 64'd1);
    step();
    check("bp_new_data", dat_z, 64'h15);
    check("bp_new_valid", {63'd0, vld_z}, 64'd1);

    // Drain with no new request: valid drops, data held.
    req_valid = 1'b0;
    step();
    check("drain_valid", {63'd0, vld_z}, 64'd0);
    check("drain_data", dat_z, 64'h15);

    // Reset while stalled drops the response.
    req_valid = 1'b1;
    req_sel   = 5'd4;
    step();
    check("stall_load", dat_z, 64'h5);
    rsp_ready = 1'b0;
    step();
    check("stall_valid", {63'd0, vld_z}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 1'b0;
    check("rst_mid_valid", {63'd0, vld_z}, 64'd0);
    check("rst_mid_data", dat_z, 64'd0);
    check("rst_mid_ready", {63'd0, rdy_z}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regread_mux
